// File: rtl/rs_scheduler_if.sv
// Issue/dispatch handshake bundle between the issue stage, the reservation
// station and the scheduler. Signal names match the scheduler's port list.
interface rs_scheduler_if #(
  parameter int RS_SIZE = 16,
  parameter int IDX_W   = 4
);
  logic               rdy_in;
  logic               issue_req_in;
  logic               issue_grant_out;
  logic [IDX_W-1:0]   rs_pos_out;
  logic               rs_full_out;
  logic [RS_SIZE-1:0] ready_vec_in;
  logic               ex_stall_in;
  logic               dispatch_en_out;
  logic [IDX_W-1:0]   dispatch_pos_out;
  logic [RS_SIZE-1:0] busy_vec_out;
  logic [IDX_W:0]     count_out;
  logic               clear_branch_in;

  modport master (
    output rdy_in, issue_req_in, ready_vec_in, ex_stall_in, clear_branch_in,
    input  issue_grant_out, rs_pos_out, rs_full_out, dispatch_en_out,
           dispatch_pos_out, busy_vec_out, count_out
  );

  modport slave (
    input  rdy_in, issue_req_in, ready_vec_in, ex_stall_in, clear_branch_in,
    output issue_grant_out, rs_pos_out, rs_full_out, dispatch_en_out,
           dispatch_pos_out, busy_vec_out, count_out
  );
endinterface

// File: rtl/rs_scheduler.sv
// Reservation-station allocator and single-issue dispatch selector.
// Define RS_AGE_ORDER_EN for oldest-first dispatch; default is lowest index first.
module rs_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int IDX_W   = 4
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  rs_scheduler_if.slave bus
);

  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(RS_SIZE);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

  logic [RS_SIZE-1:0] r_busy;
  logic [IDX_W:0]     r_count;
  logic               r_disp_en;
  logic [IDX_W-1:0]   r_disp_pos;

  logic               w_full;
  logic               w_grant;
  logic               w_dispatch;
  logic [IDX_W-1:0]   w_free_pos;
  logic [IDX_W-1:0]   w_sel_pos;
  logic [RS_SIZE-1:0] w_elig;
  logic [RS_SIZE-1:0] w_cand;
  logic [RS_SIZE-1:0] w_grant_oh;
  logic [RS_SIZE-1:0] w_disp_oh;
  logic [RS_SIZE-1:0] w_busy_nxt;

  assign w_full  = (r_count == CNT_FULL);
  assign w_grant = bus.issue_req_in & ~w_full & bus.rdy_in & ~bus.clear_branch_in;
  assign w_elig  = r_busy & bus.ready_vec_in;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_free_pos = '0;
    for (int i = RS_SIZE-1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_pos = IDX_W'(i);
    end
  end

`ifdef RS_AGE_ORDER_EN
  // r_age[i][j] set: entry i was allocated before entry j.
  logic [RS_SIZE-1:0][RS_SIZE-1:0] r_age;

  always_comb begin
    w_cand = w_elig;
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (w_elig[j] && r_age[j][i]) w_cand[i] = 1'b0;
      end
    end
  end

  // NOTE: the age matrix is reset like any other state; stale bits would
  // otherwise reorder the first dispatches after reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_age <= '0;
    end else if (bus.rdy_in) begin
      if (bus.clear_branch_in) begin
        r_age <= '0;
      end else if (w_grant) begin
        for (int j = 0; j < RS_SIZE; j++) begin
          r_age[w_free_pos][j] <= 1'b0;
          r_age[j][w_free_pos] <= r_busy[j];
        end
      end
    end
  end
`else
  assign w_cand = w_elig;
`endif

  always_comb begin
    w_sel_pos = '0;
    for (int i = RS_SIZE-1; i >= 0; i--) begin
      if (w_cand[i]) w_sel_pos = IDX_W'(i);
    end
  end

  assign w_dispatch = bus.rdy_in & ~bus.clear_branch_in & (|w_elig) & ~bus.ex_stall_in;
  assign w_grant_oh = RS_SIZE'(w_grant) << w_free_pos;
  assign w_disp_oh  = RS_SIZE'(w_dispatch) << w_sel_pos;
  // Granted and dispatched entries are disjoint: one is free, the other busy.
  assign w_busy_nxt = (r_busy | w_grant_oh) & ~w_disp_oh;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy     <= '0;
      r_count    <= '0;
      r_disp_en  <= 1'b0;
      r_disp_pos <= '0;
    end else if (bus.rdy_in) begin
      if (bus.clear_branch_in) begin
        r_busy    <= '0;
        r_count   <= '0;
        r_disp_en <= 1'b0;
      end else begin
        r_busy    <= w_busy_nxt;
        r_disp_en <= w_dispatch;
        if (w_dispatch) r_disp_pos <= w_sel_pos;
        if (w_grant && !w_dispatch) begin
          r_count <= r_count + CNT_ONE;
        end else if (!w_grant && w_dispatch) begin
          r_count <= r_count - CNT_ONE;
        end
      end
    end
  end

  assign bus.issue_grant_out  = w_grant;
  assign bus.rs_pos_out       = w_free_pos;
  assign bus.rs_full_out      = w_full;
  assign bus.dispatch_en_out  = r_disp_en;
  assign bus.dispatch_pos_out = r_disp_pos;
  assign bus.busy_vec_out     = r_busy;
  assign bus.count_out        = r_count;

endmodule

// File: tb/tb_rs_scheduler.sv
// Directed bench for rs_scheduler: reset, fill, full+dispatch, flush,
// dispatch ordering, stall, ready-hold and asynchronous reset mid-dispatch.
module tb_rs_scheduler;
  localparam int RS_SIZE = 16;
  localparam int IDX_W   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rs_scheduler_if #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W)) bus ();

  rs_scheduler #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int alloc_order [3] = '{5, 2, 9};
`ifdef RS_AGE_ORDER_EN
  int disp_order [3] = '{5, 2, 9};
`else
  int disp_order [3] = '{2, 5, 9};
`endif

  initial begin
    rst_n               = 1'b0;
    bus.rdy_in          = 1'b1;
    bus.issue_req_in    = 1'b0;
    bus.ready_vec_in    = '0;
    bus.ex_stall_in     = 1'b0;
    bus.clear_branch_in = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_busy",  bus.busy_vec_out, 32'h0);
    check("rst_count", bus.count_out, 32'd0);
    check("rst_en",    bus.dispatch_en_out, 32'd0);
    check("rst_pos",   bus.dispatch_pos_out, 32'd0);
    check("rst_full",  bus.rs_full_out, 32'd0);
    check("rst_rspos", bus.rs_pos_out, 32'd0);
    #2 rst_n = 1'b1;

    // Fill: 16 grants with nothing ready, then the 17th request is refused
    bus.issue_req_in = 1'b1;
    #1;
    for (int i = 0; i < RS_SIZE; i++) begin
      check("fill_rspos", bus.rs_pos_out, 32'(i));
      check("fill_grant", bus.issue_grant_out, 32'd1);
      tick();
    end
    check("fill_count", bus.count_out, 32'd16);
    check("fill_full",  bus.rs_full_out, 32'd1);
    check("fill_busy",  bus.busy_vec_out, 32'hffff);
    check("fill_grant17", bus.issue_grant_out, 32'd0);
    check("fill_rspos_full", bus.rs_pos_out, 32'd0);
    tick();
    check("fill_count17", bus.count_out, 32'd16);

    // Full plus dispatch of entry 3
    bus.ready_vec_in = 16'h0008;
    #1;
    check("fd_grant_full", bus.issue_grant_out, 32'd0);
    tick();
    check("fd_en",    bus.dispatch_en_out, 32'd1);
    check("fd_pos",   bus.dispatch_pos_out, 32'd3);
    check("fd_busy",  bus.busy_vec_out, 32'hfff7);
    check("fd_count", bus.count_out, 32'd15);
    bus.ready_vec_in = '0;
    #1;
    check("fd_grant_next", bus.issue_grant_out, 32'd1);
    check("fd_rspos_next", bus.rs_pos_out, 32'd3);
    tick();
    check("fd_count_refill", bus.count_out, 32'd16);
    check("fd_en_idle", bus.dispatch_en_out, 32'd0);
    check("fd_pos_hold", bus.dispatch_pos_out, 32'd3);

    // Flush from full
    bus.clear_branch_in = 1'b1;
    #1;
    check("fl0_grant", bus.issue_grant_out, 32'd0);
    tick();
    check("fl0_busy",  bus.busy_vec_out, 32'h0);
    check("fl0_count", bus.count_out, 32'd0);
    bus.clear_branch_in = 1'b0;

    // Flush with 6 busy entries and a dispatch in flight
    repeat (7) tick();
    bus.issue_req_in = 1'b0;
    bus.ready_vec_in = 16'h0001;
    tick();
    check("fl_pre_en",    bus.dispatch_en_out, 32'd1);
    check("fl_pre_busy",  bus.busy_vec_out, 32'h007e);
    check("fl_pre_count", bus.count_out, 32'd6);
    bus.ready_vec_in    = '0;
    bus.issue_req_in    = 1'b1;
    bus.clear_branch_in = 1'b1;
    #1;
    check("fl_grant", bus.issue_grant_out, 32'd0);
    tick();
    check("fl_busy",  bus.busy_vec_out, 32'h0);
    check("fl_count", bus.count_out, 32'd0);
    check("fl_en",    bus.dispatch_en_out, 32'd0);
    bus.clear_branch_in = 1'b0;

    // Ordering: fill, then reallocate entries 5, 2, 9 in that order
    repeat (RS_SIZE) tick();
    bus.issue_req_in = 1'b0;
    check("ord_fill_count", bus.count_out, 32'd16);
    for (int i = 0; i < 3; i++) begin
      bus.ready_vec_in = 16'(1) << alloc_order[i];
      tick();
      check("ord_free_pos", bus.dispatch_pos_out, 32'(alloc_order[i]));
      bus.ready_vec_in = '0;
      bus.issue_req_in = 1'b1;
      #1;
      check("ord_alloc_pos", bus.rs_pos_out, 32'(alloc_order[i]));
      tick();
      bus.issue_req_in = 1'b0;
    end
    bus.ready_vec_in = 16'h0224;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ord_en",  bus.dispatch_en_out, 32'd1);
      check("ord_pos", bus.dispatch_pos_out, 32'(disp_order[i]));
    end
    tick();
    check("ord_en_done", bus.dispatch_en_out, 32'd0);
    check("ord_count",   bus.count_out, 32'd13);
    check("ord_busy",    bus.busy_vec_out, 32'hfddb);
    bus.ready_vec_in = '0;

    // Stall: entry 0 ready but ALU blocked
    bus.clear_branch_in = 1'b1;
    tick();
    bus.clear_branch_in = 1'b0;
    bus.issue_req_in    = 1'b1;
    tick();
    bus.issue_req_in = 1'b0;
    bus.ready_vec_in = 16'h0001;
    bus.ex_stall_in  = 1'b1;
    tick();
    check("st_en",   bus.dispatch_en_out, 32'd0);
    check("st_busy", bus.busy_vec_out, 32'h0001);
    tick();
    check("st_en2",  bus.dispatch_en_out, 32'd0);
    check("st_pos_hold", bus.dispatch_pos_out, 32'd9);
    bus.ex_stall_in = 1'b0;
    tick();
    check("st_rel_en",    bus.dispatch_en_out, 32'd1);
    check("st_rel_pos",   bus.dispatch_pos_out, 32'd0);
    check("st_rel_busy",  bus.busy_vec_out, 32'h0);
    check("st_rel_count", bus.count_out, 32'd0);

    // Global ready low holds everything and blocks grants
    bus.rdy_in       = 1'b0;
    bus.issue_req_in = 1'b1;
    bus.ready_vec_in = 16'hffff;
    #1;
    check("rdy_grant", bus.issue_grant_out, 32'd0);
    tick();
    check("rdy_en_hold", bus.dispatch_en_out, 32'd1);
    check("rdy_count",   bus.count_out, 32'd0);
    check("rdy_busy",    bus.busy_vec_out, 32'h0);
    bus.rdy_in       = 1'b1;
    bus.ready_vec_in = '0;

    // Asynchronous reset in the middle of a dispatch
    tick();
    tick();
    bus.ready_vec_in = 16'h0001;
    tick();
    check("ar_pre_en",   bus.dispatch_en_out, 32'd1);
    check("ar_pre_busy", bus.busy_vec_out, 32'h0006);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy",  bus.busy_vec_out, 32'h0);
    check("ar_count", bus.count_out, 32'd0);
    check("ar_en",    bus.dispatch_en_out, 32'd0);
    check("ar_pos",   bus.dispatch_pos_out, 32'd0);
    bus.ready_vec_in = 16'hffff;
    tick();
    check("ar_hold_count", bus.count_out, 32'd0);
    #2 rst_n = 1'b1;
    bus.ready_vec_in = '0;
    tick();
    check("ar_resume_count", bus.count_out, 32'd1);
    check("ar_resume_busy",  bus.busy_vec_out, 32'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs_scheduler.md
RS_SCHEDULER -- requirements
Module: rs_scheduler

Interface
REQ-001 SHALL have parameter RS_SIZE, default 16: reservation-station entry count (power of two, 2..32).
REQ-002 SHALL have parameter IDX_W, default 4: entry index width, log2(RS_SIZE).
REQ-003 SHALL have port clk_in, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n_in, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in, input, 1: global ready; low freezes all state.
REQ-006 SHALL have port issue_req_in, input, 1: issue stage holds an instruction bound for the RS.
REQ-007 SHALL have port issue_grant_out, output, 1: combinational RS write enable for this cycle.
REQ-008 SHALL have port rs_pos_out, output, IDX_W: combinational lowest-index free entry; 0 when full.
REQ-009 SHALL have port rs_full_out, output, 1: combinational; all entries busy.
REQ-010 SHALL have port ready_vec_in, input, RS_SIZE: per-entry operands-ready (q1==0 and q2==0) from the RS.
REQ-011 SHALL have port ex_stall_in, input, 1: ALU cannot accept a dispatch this cycle.
REQ-012 SHALL have port dispatch_en_out, output, 1: registered; selected entry is sent to the ALU.
REQ-013 SHALL have port dispatch_pos_out, output, IDX_W: registered index of the dispatched entry.
REQ-014 SHALL have port busy_vec_out, output, RS_SIZE: registered busy bit per entry.
REQ-015 SHALL have port count_out, output, IDX_W+1: registered occupied-entry count.
REQ-016 SHALL have port clear_branch_in, input, 1: misprediction flush.

Function
REQ-017 SHALL drive issue_grant_out = issue_req_in and not rs_full_out and rdy_in and not clear_branch_in.
REQ-018 SHALL, on an edge with issue_grant_out high, set busy_vec_out[rs_pos_out].
REQ-019 SHALL treat an entry as eligible when busy and ready_vec_in set; an entry allocated this edge is never eligible before the next cycle.
REQ-020 SHALL, each rdy_in edge with no flush, set dispatch_en_out to 1 iff an eligible entry exists and ex_stall_in is low, else 0.
REQ-021 SHALL, when dispatching, load dispatch_pos_out with the selected index and clear its busy bit on the same edge (one-cycle latency, at most one dispatch per cycle).
REQ-022 SHALL hold dispatch_pos_out when dispatch_en_out is 0.
REQ-023 SHALL update count_out: +1 on grant only, -1 on dispatch only, unchanged on both or neither; count_out always equals popcount(busy_vec_out).
REQ-024 SHALL allow grant and dispatch in the same cycle; the freed entry is reusable only from the next cycle.
REQ-025 SHALL raise rs_full_out only when count_out == RS_SIZE; grant is then 0 regardless of a same-cycle dispatch.
REQ-026 SHALL, on an edge with clear_branch_in high, clear busy_vec_out, count_out, age state and dispatch_en_out, overriding any grant or dispatch.
REQ-027 SHALL, with rdy_in low, hold every register (including dispatch_en_out) and force issue_grant_out to 0.

Reset
REQ-028 SHALL, while rst_n_in is low, asynchronously clear busy_vec_out, count_out, dispatch_en_out, dispatch_pos_out and all age state.
REQ-029 SHALL ignore all inputs during reset and resume normal operation on the first rising edge after rst_n_in rises.

Configuration
REQ-030 SHALL, with RS_AGE_ORDER_EN defined, keep an RS_SIZE x RS_SIZE age matrix (age[i][j]=1: i older than j); on allocating k, age[k][*]=0 and age[*][k]=busy[*]; select the eligible entry with no older eligible entry.
REQ-031 SHALL, with RS_AGE_ORDER_EN undefined, omit the age matrix and select the lowest-index eligible entry.

Verification
REQ-032 SHALL cover reset: rst_n_in low mid-dispatch -> busy_vec_out=0, count_out=0, dispatch_en_out=0 immediately, before any clock edge.
REQ-033 SHALL cover fill: 16 consecutive grants, ready_vec_in=0 -> rs_pos_out 0..15, count_out=16, rs_full_out=1, 17th request gets grant 0.
REQ-034 SHALL cover ordering: allocate entries 5, 2, 9 in that order, all ready together -> with macro dispatch order 5, 2, 9; without, order 2, 5, 9.
REQ-035 SHALL cover full plus dispatch: full RS, entry 3 ready, issue_req_in=1 -> grant 0 this cycle, dispatch_pos_out=3, next cycle grant 1 with rs_pos_out=3.
REQ-036 SHALL cover flush: 6 busy entries, clear_branch_in and issue_req_in both high -> grant 0, next cycle busy_vec_out=0, count_out=0, dispatch_en_out=0.
REQ-037 SHALL cover stall: ex_stall_in=1 with entry 0 ready -> dispatch_en_out=0, entry 0 stays busy; stall drops -> dispatch_pos_out=0 next cycle.
